nibble_serial_adder64: RTL and testbench

//  Multi-cycle 64-bit adder front-end: accepts two operands plus carry-in via valid/ready,

---
 rtl/nibble_serial_adder64_pkg.sv | 16 +
 rtl/nibble_serial_adder64_fa4.sv | 26 ++
 rtl/nibble_serial_adder64.sv | 131 +++++++++++++
 tb/tb_nibble_serial_adder64.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder64_pkg.sv
// Shared constants for the nibble-serial adder: FSM state encoding, slice width
// and the signed-overflow rule applied to the final nibble.
package nibble_serial_adder64_pkg;

   localparam int NIBBLE_W = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Overflow when both operands share a sign and the result sign differs.
   function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/nibble_serial_adder64_fa4.sv
// FullAdder4: the team's 4-bit ripple-carry slice, reused one nibble per clock
// by the serial adder.
module FullAdder4
   import nibble_serial_adder64_pkg::*;
(
   input  logic [NIBBLE_W-1:0] A,
   input  logic [NIBBLE_W-1:0] B,
   input  logic                Cin,
   output logic [NIBBLE_W-1:0] S,
   output logic                Cout
);

   logic [NIBBLE_W:0] w_c;

   always_comb begin
      w_c    = '0;
      S      = '0;
      w_c[0] = Cin;
      for (int i = 0; i < NIBBLE_W; i++) begin
         S[i]     = A[i] ^ B[i] ^ w_c[i];
         w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
      end
      Cout = w_c[NIBBLE_W];
   end

endmodule

// File: rtl/nibble_serial_adder64.sv
// Multi-cycle WIDTH-bit adder: operands are latched on a valid/ready accept and
// summed one nibble per clock (LSB first) through a single 4-bit ripple slice.
module nibble_serial_adder64
   import nibble_serial_adder64_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

   generate
      if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 2 * NIBBLE_W) begin : g_width_chk
         $error("nibble_serial_adder64: WIDTH must be a multiple of 4 and at least 8");
      end
   endgenerate

   logic [1:0]          r_state;
   logic [1:0]          w_next_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_carry;
   logic [WIDTH-1:0]    r_a;
   logic [WIDTH-1:0]    r_b;
   logic [WIDTH-1:0]    r_acc;
   logic                r_a_msb;
   logic                r_b_msb;
   logic [WIDTH-1:0]    r_sum;
   logic                r_cout;
   logic                r_ovf;

   logic                w_accept;
   logic                w_last;
   logic [NIBBLE_W-1:0] w_slice_s;
   logic                w_slice_c;
   logic [WIDTH-1:0]    w_acc_next;

   assign w_accept   = in_valid && (r_state == ST_IDLE);
   assign w_last     = (r_cnt == LAST_CNT);
   // New nibble enters at the top so after NIBBLES shifts nibble 0 sits at the bottom.
   assign w_acc_next = {w_slice_s, r_acc[WIDTH-1:NIBBLE_W]};

   FullAdder4 u_slice (
      .A    (r_a[NIBBLE_W-1:0]),
      .B    (r_b[NIBBLE_W-1:0]),
      .Cin  (r_carry),
      .S    (w_slice_s),
      .Cout (w_slice_c)
   );

   always_comb begin
      w_next_state = ST_IDLE;
      case (r_state)
         ST_IDLE: w_next_state = w_accept ? ST_RUN : ST_IDLE;
         ST_RUN:  w_next_state = w_last ? ST_DONE : ST_RUN;
         ST_DONE: w_next_state = out_ready ? ST_IDLE : ST_DONE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_acc   <= '0;
         r_a_msb <= 1'b0;
         r_b_msb <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_carry <= cin;
                  r_cnt   <= '0;
                  r_a_msb <= a[WIDTH-1];
                  r_b_msb <= b[WIDTH-1];
               end
            end
            ST_RUN: begin
               r_a     <= r_a >> NIBBLE_W;
               r_b     <= r_b >> NIBBLE_W;
               r_acc   <= w_acc_next;
               r_carry <= w_slice_c;
               if (w_last) begin
                  // Outputs only change here, so they stay stable through DONE and after.
                  r_sum  <= w_acc_next;
                  r_cout <= w_slice_c;
                  r_ovf  <= signed_ovf(r_a_msb, r_b_msb, w_slice_s[NIBBLE_W-1]);
               end else begin
                  r_cnt  <= r_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = (r_state == ST_DONE);
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder64.sv
// Directed and randomised bench for nibble_serial_adder64 against an a+b+cin model.
module tb_nibble_serial_adder64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] a = '0;
   logic [63:0] b = '0;
   logic        cin = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] sum;
   logic        cout;
   logic        ovf;

   int n_tests = 0;
   int n_fail  = 0;

   nibble_serial_adder64 #(.WIDTH(64)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic [63:0] op_a, input logic [63:0] op_b, input logic op_c);
      int n;
      n = 0;
      while (!in_ready && n < 64) begin
         tick();
         n++;
      end
      chk("in_ready_wait", in_ready, 1'b1);
      a        = op_a;
      b        = op_b;
      cin      = op_c;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 64) begin
         tick();
         lat++;
      end
   endtask

   task automatic handshake;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   function automatic logic [65:0] model(input logic [63:0] ma, input logic [63:0] mb, input logic mc);
      logic [64:0] s;
      logic        v;
      s = {1'b0, ma} + {1'b0, mb} + {64'd0, mc};
      v = (ma[63] == mb[63]) && (s[63] != ma[63]);
      return {v, s};
   endfunction

   initial begin
      int          lat;
      int          got;
      int          cyc;
      logic [65:0] q[$];
      logic [65:0] e;

      // reset values
      #1;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_sum", sum, 64'd0);
      chk("rst_cout", cout, 1'b0);
      chk("rst_ovf", ovf, 1'b0);
      #3 rst_n = 1'b1;
      tick();

      // 1 + 1
      start_op(64'd1, 64'd1, 1'b0);
      wait_out(lat);
      chk("t1_latency", lat, 16);
      chk("t1_sum", sum, 64'd2);
      chk("t1_cout", cout, 1'b0);
      chk("t1_ovf", ovf, 1'b0);
      handshake();
      chk("t1_valid_drop", out_valid, 1'b0);
      chk("t1_ready_back", in_ready, 1'b1);
      chk("t1_sum_kept", sum, 64'd2);

      // carry ripples through all nibbles
      start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
      wait_out(lat);
      chk("t2_latency", lat, 16);
      chk("t2_sum", sum, 64'd0);
      chk("t2_cout", cout, 1'b1);
      chk("t2_ovf", ovf, 1'b0);
      handshake();

      // signed overflow
      start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      wait_out(lat);
      chk("t3_sum", sum, 64'h8000_0000_0000_0000);
      chk("t3_cout", cout, 1'b0);
      chk("t3_ovf", ovf, 1'b1);
      handshake();

      // back-pressure in DONE with competing input requests
      start_op(64'd5, 64'd7, 1'b1);
      wait_out(lat);
      for (int i = 0; i < 5; i++) begin
         a        = 64'hDEAD_0000_0000_0000 + 64'(i);
         b        = 64'h1234;
         cin      = 1'b1;
         in_valid = 1'b1;
         tick();
         chk("t4_valid_hold", out_valid, 1'b1);
         chk("t4_in_ready_low", in_ready, 1'b0);
         chk("t4_sum_hold", sum, 64'd13);
         chk("t4_cout_hold", cout, 1'b0);
         chk("t4_ovf_hold", ovf, 1'b0);
      end
      in_valid = 1'b0;
      handshake();
      chk("t4_valid_drop", out_valid, 1'b0);
      chk("t4_ready_back", in_ready, 1'b1);
      tick();
      chk("t4_no_phantom", in_ready, 1'b1);
      chk("t4_sum_kept", sum, 64'd13);

      // asynchronous reset mid-RUN
      start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      repeat (8) tick();
      rst_n = 1'b0;
      #1;
      chk("t5_rst_in_ready", in_ready, 1'b1);
      chk("t5_rst_out_valid", out_valid, 1'b0);
      chk("t5_rst_sum", sum, 64'd0);
      chk("t5_rst_cout", cout, 1'b0);
      chk("t5_rst_ovf", ovf, 1'b0);
      #2 rst_n = 1'b1;
      tick();
      chk("t5_idle_after", out_valid, 1'b0);
      start_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0);
      wait_out(lat);
      chk("t5_latency", lat, 16);
      chk("t5_sum", sum, 64'h1234_5678_9ABC_DF00);
      chk("t5_cout", cout, 1'b0);
      chk("t5_ovf", ovf, 1'b0);
      handshake();

      // back-to-back random traffic
      got      = 0;
      cyc      = 0;
      in_valid = 1'b1;
      while (got < 1000 && cyc < 40000) begin
         a         = {$urandom, $urandom};
         b         = {$urandom, $urandom};
         cin       = 1'($urandom);
         out_ready = 1'($urandom);
         #1;
         if (in_valid && in_ready) q.push_back(model(a, b, cin));
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("rnd_duplicate", 1'b1, 1'b0);
            end else begin
               e = q.pop_front();
               chk("rnd_sum", sum, e[63:0]);
               chk("rnd_cout", cout, e[64]);
               chk("rnd_ovf", ovf, e[65]);
            end
            got++;
         end
         tick();
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("rnd_count", got, 1000);
      chk("rnd_leftover", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
